// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating a 25-series serial flash over a byte-wide memory port.
// Optional FAST READ (0x0B) support is enabled by defining SPI_FLASH_RESPONDER_FASTREAD_EN.
module spi_flash_responder #(
  parameter int unsigned ADDR_W      = 24,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int unsigned BUSY_CYCLES = 4800
) (
  input  logic              clk_48mhz,
  input  logic              reset,
  input  logic              spi_csel,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              busy
);

  localparam int unsigned BUSY_W = $clog2(BUSY_CYCLES + 1);

  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_RDID = 8'h9F;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_STAT_OUT, S_ID_OUT,
    S_DATA_OUT, S_DATA_IN, S_DUMMY, S_IGNORE
  } state_t;

  // synchronizers and edge detection
  logic csel_meta_q, csel_s_q;
  logic sclk_meta_q, sclk_s_q, sclk_prev_q;
  logic mosi_meta_q, mosi_s_q;
  logic sclk_rise, sclk_fall;

  state_t              state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [22:0]         shift_in_q, shift_in_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          rbuf_q, rbuf_d;
  logic                rd_wait_q, rd_wait_d;
  logic [1:0]          id_idx_q, id_idx_d;
  logic                pend_q, pend_d;
  logic                pp_any_q, pp_any_d;
  logic                wel_q, wel_d;
  logic                wip_q, wip_d;
  logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic                miso_q, miso_d;
  logic                oe_q, oe_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;

  logic [23:0]         in_word;
  logic [ADDR_W-1:0]   rx_addr;
  logic [7:0]          load_byte;

  assign sclk_rise = sclk_s_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s_q & sclk_prev_q;
  assign in_word   = {shift_in_q, mosi_s_q};
  assign rx_addr   = ADDR_W'(in_word);

  // byte presented at the start of each output byte
  always_comb begin
    load_byte = 8'hFF;
    case (state_q)
      S_STAT_OUT: load_byte = {6'b0, wel_q, wip_q};
      S_ID_OUT: begin
        case (id_idx_q)
          2'd0:    load_byte = JEDEC_ID[23:16];
          2'd1:    load_byte = JEDEC_ID[15:8];
          2'd2:    load_byte = JEDEC_ID[7:0];
          default: load_byte = 8'h00;
        endcase
      end
      S_DATA_OUT: load_byte = rbuf_q;
      default:    load_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    rbuf_d      = rbuf_q;
    rd_wait_d   = mem_rd_q;
    id_idx_d    = id_idx_q;
    pend_d      = pend_q;
    pp_any_d    = pp_any_q;
    wel_d       = wel_q;
    wip_d       = wip_q;
    busy_cnt_d  = busy_cnt_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (rd_wait_q) rbuf_d = mem_rdata;

    // program busy timer; WEL drops together with WIP
    if (wip_q) begin
      if (busy_cnt_q <= BUSY_W'(1)) begin
        wip_d      = 1'b0;
        wel_d      = 1'b0;
        busy_cnt_d = '0;
      end else begin
        busy_cnt_d = busy_cnt_q - BUSY_W'(1);
      end
    end

    if (csel_s_q) begin
      if (state_q == S_IGNORE && pend_q) wel_d = (opcode_q == OP_WREN);
      if (state_q == S_DATA_IN && pp_any_q) begin
        wip_d      = 1'b1;
        busy_cnt_d = BUSY_W'(BUSY_CYCLES);
      end
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      miso_d    = 1'b1;
      oe_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_CMD;
          bit_cnt_d = '0;
          miso_d    = 1'b1;
          oe_d      = 1'b0;
        end
        S_CMD: begin
          if (sclk_rise) begin
            shift_in_d = in_word[22:0];
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              opcode_d  = in_word[7:0];
              bit_cnt_d = '0;
              id_idx_d  = '0;
              state_d   = S_IGNORE;
              case (in_word[7:0])
                OP_READ: if (!wip_q) state_d = S_ADDR;
`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
                OP_FAST: if (!wip_q) state_d = S_ADDR;
`endif
                OP_RDSR: begin
                  state_d = S_STAT_OUT;
                  oe_d    = 1'b1;
                end
                OP_RDID: begin
                  if (!wip_q) begin
                    state_d = S_ID_OUT;
                    oe_d    = 1'b1;
                  end
                end
                OP_WREN, OP_WRDI: pend_d = ~wip_q;
                OP_PP: if (wel_q && !wip_q) state_d = S_ADDR;
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            shift_in_d = in_word[22:0];
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              if (opcode_q == OP_PP) begin
                state_d  = S_DATA_IN;
                addr_d   = rx_addr;
                pp_any_d = 1'b0;
              end else begin
                mem_rd_d   = 1'b1;
                mem_addr_d = rx_addr;
                addr_d     = rx_addr + ADDR_W'(1);
                oe_d       = 1'b1;
                state_d    = (opcode_q == OP_FAST) ? S_DUMMY : S_DATA_OUT;
              end
            end
          end
        end
        S_DUMMY: begin
          if (sclk_fall) miso_d = 1'b1;
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = S_DATA_OUT;
            end
          end
        end
        S_STAT_OUT, S_ID_OUT, S_DATA_OUT: begin
          if (sclk_fall) begin
            if (bit_cnt_q[2:0] == 3'd0) begin
              miso_d = load_byte[7];
              tx_d   = {load_byte[6:0], 1'b0};
              if (state_q == S_ID_OUT && id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
          end
          // prefetch the following byte once the MSB of this one has been taken
          if (sclk_rise && state_q == S_DATA_OUT && bit_cnt_q[2:0] == 3'd1) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q;
            addr_d     = addr_q + ADDR_W'(1);
          end
        end
        S_DATA_IN: begin
          if (sclk_rise) begin
            shift_in_d = in_word[22:0];
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d   = '0;
              mem_wr_d    = 1'b1;
              mem_wdata_d = in_word[7:0];
              mem_addr_d  = addr_q;
              addr_d      = {addr_q[ADDR_W-1:8], addr_q[7:0] + 8'd1};
              pp_any_d    = 1'b1;
            end
          end
        end
        default: begin
          if (sclk_rise) pend_d = 1'b0;
          miso_d = 1'b1;
          oe_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      csel_meta_q <= 1'b1;
      csel_s_q    <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_s_q    <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      opcode_q    <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      rbuf_q      <= '0;
      rd_wait_q   <= 1'b0;
      id_idx_q    <= '0;
      pend_q      <= 1'b0;
      pp_any_q    <= 1'b0;
      wel_q       <= 1'b0;
      wip_q       <= 1'b0;
      busy_cnt_q  <= '0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      csel_meta_q <= spi_csel;
      csel_s_q    <= csel_meta_q;
      sclk_meta_q <= spi_clk;
      sclk_s_q    <= sclk_meta_q;
      sclk_prev_q <= sclk_s_q;
      mosi_meta_q <= spi_mosi;
      mosi_s_q    <= mosi_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      rbuf_q      <= rbuf_d;
      rd_wait_q   <= rd_wait_d;
      id_idx_q    <= id_idx_d;
      pend_q      <= pend_d;
      pp_any_q    <= pp_any_d;
      wel_q       <= wel_d;
      wip_q       <= wip_d;
      busy_cnt_q  <= busy_cnt_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = wip_q;

endmodule
